// File: rtl/seq_adder_pkg.sv
// Shared definitions for the sequential adder: FSM state encoding and an
// index-width helper used to size the chunk counter.
package seq_adder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  // Number of bits needed to count 0..value-1; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits = bits + 1;
      rem  = rem >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/chunk_add.sv
// Combinational CHUNK-bit ripple-carry adder slice built from fulladd cells.
// The top reuses a single instance of this slice on every RUN cycle.
module chunk_add #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    fulladd u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .s   (s[i]),
      .cout(c[i+1])
    );
  end

  assign cout = c[CHUNK];

endmodule

// File: rtl/fulladd.sv
// One-bit full adder cell; the building block of the chunk ripple.
module fulladd (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/seq_adder_n.sv
// Multi-cycle WIDTH-bit adder: CHUNK bits per clock through a carry register.
// Define SEQ_ADDER_SUB_EN to add a 'sub' port that computes x + ~y + 1.
module seq_adder_n
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SEQ_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic             start,
  input  logic             carryin,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout
);

  localparam int NCH = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  localparam int IW  = (NCH > 1) ? clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  if (WIDTH < 1) begin : g_bad_width
    $error("seq_adder_n: WIDTH must be >= 1");
  end
  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
    $error("seq_adder_n: WIDTH must be a multiple of CHUNK");
  end

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic             carry_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] s_chunk;
  logic             c_next;
  logic             accept;
  logic             last;
  logic             sub_sel;

`ifdef SEQ_ADDER_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  // A new add is taken only from IDLE or DONE; start during RUN is dropped.
  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last   = (idx_q == LAST);

  assign a_chunk = x_q[idx_q*CHUNK +: CHUNK];
  assign b_chunk = y_q[idx_q*CHUNK +: CHUNK];

  chunk_add #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a   (a_chunk),
    .b   (b_chunk),
    .cin (carry_q),
    .s   (s_chunk),
    .cout(c_next)
  );

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, independent of the order the always blocks run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // NOTE: all datapath registers are plain flops (no memory arrays), so each
  // one takes the reset; a mid-run reset therefore clears any partial sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      // Subtract folds into the add: invert y and force the carry-in to 1.
      x_q     <= x;
      y_q     <= sub_sel ? ~y : y;
      carry_q <= sub_sel | carryin;
      idx_q   <= '0;
    end else if (state_q == S_RUN) begin
      sum_q[idx_q*CHUNK +: CHUNK] <= s_chunk;
      carry_q                     <= c_next;
      idx_q                       <= idx_q + IW'(1);
      if (last) begin
        cout_q <= c_next;
      end
    end
  end

  assign sum      = sum_q;
  assign carryout = cout_q;

endmodule

// File: tb/tb_seq_adder_n.sv
// Scoreboard bench for seq_adder_n: a cycle-count reference model queues the
// expected result of each accepted start and a monitor checks on every cycle.
module tb_seq_adder_n;

  localparam int W   = 8;
  localparam int C   = 2;
  localparam int NCH = W / C;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
  } res_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         cin;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         sub_tb;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carryout;

  logic         start4;
  logic         cin4;
  logic [3:0]   x4;
  logic [3:0]   y4;
  logic         sub4;
  logic         busy4;
  logic         done4;
  logic [3:0]   sum4;
  logic         cout4;

  int   n_vec = 0;
  int   n_err = 0;

  res_t exp_q[$];
  int   remaining = 0;
  bit   done_exp  = 1'b0;
  res_t inflight  = '0;
  res_t hold      = '0;
  res_t mon_r;

  seq_adder_n #(.WIDTH(W), .CHUNK(C)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef SEQ_ADDER_SUB_EN
    .sub     (sub_tb),
`endif
    .start   (start),
    .carryin (cin),
    .x       (x),
    .y       (y),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .carryout(carryout)
  );

  seq_adder_n #(.WIDTH(4), .CHUNK(4)) u_dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef SEQ_ADDER_SUB_EN
    .sub     (sub4),
`endif
    .start   (start4),
    .carryin (cin4),
    .x       (x4),
    .y       (y4),
    .busy    (busy4),
    .done    (done4),
    .sum     (sum4),
    .carryout(cout4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
    end
  endtask

  // Reference result from plain integer arithmetic on WIDTH+1 bits.
  function automatic res_t ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic sb);
    logic [W:0] t;
    if (sb) t = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else    t = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
    return '{sum: t[W-1:0], cout: t[W]};
  endfunction

  // Timing model: an accepted start keeps the unit busy for NCH edges, then
  // the result is presented for one cycle during which a new start is taken.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= 0;
      done_exp  <= 1'b0;
      hold      <= '0;
      exp_q.delete();
    end else if (remaining > 0) begin
      remaining <= remaining - 1;
      done_exp  <= (remaining == 1);
      if (remaining == 1) hold <= inflight;
    end else begin
      done_exp <= 1'b0;
      if (start) begin
        exp_q.push_back(ref_add(x, y, cin, sub_tb));
        inflight  <= ref_add(x, y, cin, sub_tb);
        remaining <= NCH;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", {31'b0, busy}, {31'b0, remaining != 0});
    check("done", {31'b0, done}, {31'b0, done_exp});
    if (done) begin
      check("queue_nonempty", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        mon_r = exp_q.pop_front();
        check("sum", {24'b0, sum}, {24'b0, mon_r.sum});
        check("carryout", {31'b0, carryout}, {31'b0, mon_r.cout});
      end
    end
    if (remaining == 0) begin
      check("hold_sum", {24'b0, sum}, {24'b0, hold.sum});
      check("hold_cout", {31'b0, carryout}, {31'b0, hold.cout});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // One-cycle start pulse; operands are scrambled right after capture.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic sb);
    start  = 1'b1;
    x      = a;
    y      = b;
    cin    = ci;
    sub_tb = sb;
    tick();
    start  = 1'b0;
    x      = W'($urandom);
    y      = W'($urandom);
    cin    = 1'($urandom);
    sub_tb = 1'b0;
  endtask

  initial begin
    logic [4:0] exp5;
    rst_n  = 1'b0;
    start  = 1'b0;
    cin    = 1'b0;
    x      = '0;
    y      = '0;
    sub_tb = 1'b0;
    start4 = 1'b0;
    cin4   = 1'b0;
    x4     = '0;
    y4     = '0;
    sub4   = 1'b0;
    idle(3);
    check("reset_sum", {24'b0, sum}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    issue(8'h01, 8'h01, 1'b0, 1'b0);
    idle(NCH + 3);
    check("basic_sum", {24'b0, sum}, 32'h02);
    issue(8'hFF, 8'h00, 1'b1, 1'b0);
    idle(NCH + 2);
    check("chain_sum", {23'b0, carryout, sum}, 32'h100);
    issue(8'h0B, 8'h04, 1'b0, 1'b0);
    idle(NCH + 2);
    issue(8'h0C, 8'h03, 1'b1, 1'b0);
    idle(NCH + 2);
    check("mixed_sum", {24'b0, sum}, 32'h10);

    // Start held high with operands changing every cycle: back-to-back adds.
    start = 1'b1;
    for (int i = 0; i < 3 * (NCH + 1); i++) begin
      x   = W'($urandom);
      y   = W'($urandom);
      cin = 1'($urandom);
      tick();
    end
    start = 1'b0;
    idle(NCH + 2);

    // Reset asserted mid-run: outputs clear at once and no done follows.
    issue(8'h7F, 8'h7F, 1'b1, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_sum", {24'b0, sum}, 32'd0);
    check("midrst_cout", {31'b0, carryout}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    idle(NCH + 3);

`ifdef SEQ_ADDER_SUB_EN
    issue(8'h05, 8'h07, 1'b1, 1'b1);
    idle(NCH + 2);
    check("sub_result", {23'b0, carryout, sum}, 32'h0FE);
`endif

    for (int i = 0; i < 400; i++) begin
      start  = ($urandom_range(0, 2) == 0);
      x      = W'($urandom);
      y      = W'($urandom);
      cin    = 1'($urandom);
      sub_tb = 1'b0;
`ifdef SEQ_ADDER_SUB_EN
      sub_tb = 1'($urandom);
`endif
      tick();
    end
    start  = 1'b0;
    sub_tb = 1'b0;
    idle(NCH + 3);

    // WIDTH == CHUNK: one RUN cycle, done on the second edge after start.
    for (int i = 0; i < 6; i++) begin
      start4 = 1'b1;
      x4     = (i == 0) ? 4'h9 : 4'($urandom);
      y4     = (i == 0) ? 4'h8 : 4'($urandom);
      cin4   = (i == 0) ? 1'b1 : 1'($urandom);
      exp5   = {1'b0, x4} + {1'b0, y4} + {4'b0, cin4};
      tick();
      start4 = 1'b0;
      x4     = 4'($urandom);
      y4     = 4'($urandom);
      @(negedge clk);
      check("w4_busy_run", {31'b0, busy4}, 32'd1);
      check("w4_done_run", {31'b0, done4}, 32'd0);
      tick();
      @(negedge clk);
      check("w4_busy_done", {31'b0, busy4}, 32'd0);
      check("w4_done", {31'b0, done4}, 32'd1);
      check("w4_sum", {27'b0, cout4, sum4}, {27'b0, exp5});
      tick();
      @(negedge clk);
      check("w4_done_pulse", {31'b0, done4}, 32'd0);
      check("w4_hold", {27'b0, cout4, sum4}, {27'b0, exp5});
    end

    idle(2);
    check("drain", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
